chaves_debounce_irq_ctrl: RTL
=============================

// Module: chaves_debounce_irq_ctrl
// PURPOSE
//  Avalon-MM slave controller for the board slide switches: synchronizes and debounces each
//  switch bit, detects edges, latches them in a write-1-to-clear capture register and raises
//  a maskable interrupt to the HPS. Sits between the raw switch pins and the HPS lightweight
//  bridge in place of a plain input PIO; software reads clean levels and services edge IRQs.
// PARAMETERS
//  WIDTH           10      number of switch inputs (1..32)
//  DEBOUNCE_CYCLES 50000   consecutive stable clk cycles before a level is accepted (>=2)
// PORTS
//  clk         in   1      system clock; one clock domain
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select (word address)
//  chipselect  in   1      slave select
//  write       in   1      write strobe; effective only when chipselect=1
//  writedata   in   32     write data
//  readdata    out  32     registered read data, 1-cycle latency
//  in_port     in   WIDTH  raw asynchronous switch inputs
//  irq         out  1      level interrupt, registered
// BEHAVIOUR
//  Registers (unused upper bits read 0, writes ignored):
//   0 DATA     RO  debounced levels deb[WIDTH-1:0]
//   1 IRQMASK  RW  per-bit interrupt enable, reset 0
//   2 EDGECAP  RW1C  per-bit edge flags, reset 0; writing 1 clears a bit, 0 leaves it
//   3 EDGESEL  RW  bits[1:0]: 00 rising, 01 falling, 1x both; reset 00
//  Sync: 2-FF synchronizer per bit (s1->s2); s2 reset 0.
//  Debounce per bit: counter width clog2(DEBOUNCE_CYCLES); if s2==deb counter<=0; else if
//   counter==DEBOUNCE_CYCLES-1 then deb<=s2, counter<=0; else counter++. deb resets 0.
//   Any glitch (s2 returns to deb) before terminal count restarts the count from 0.
//  Edge detect: deb_q is deb delayed 1 cycle (reset 0); rise=deb&~deb_q, fall=~deb&deb_q;
//   ev selected by EDGESEL. EDGECAP <= (EDGECAP & ~clr) | ev.
//   Simultaneous set and W1C clear of the same bit: set wins (bit stays 1).
//  irq <= |(EDGECAP & IRQMASK) each cycle; reset 0. Mask change reflected on irq 1 cycle later.
//  Latency: in_port change held stable from edge 0 -> deb updates at edge DEBOUNCE_CYCLES+2,
//   EDGECAP bit at +3, irq at +4.
//  readdata <= register[address] every cycle (no read strobe); reset 0.
//  Bits held high through reset are seen as a rising edge once debounced after reset; this is
//   intended (software clears EDGECAP at init).
//  Reset mid-operation: all counters, deb, deb_q, EDGECAP, IRQMASK, EDGESEL, irq, readdata -> 0
//   on the next clk edge regardless of other inputs.
//  Writes with chipselect=0 are ignored; writes to address 0 are ignored.
// TESTING (DEBOUNCE_CYCLES=4, WIDTH=10)
//  1 Reset: assert reset 2 cycles with in_port=0 -> readdata=0, irq=0, all regs read 0.
//  2 Debounce: in_port[3] 0->1 held -> DATA=0x008 appears on readdata (addr 0) 7 cycles after
//    change (6 to deb + 1 read latency); a 3-cycle pulse on in_port[3] never changes DATA.
//  3 IRQ: IRQMASK=0x008, EDGESEL=00, raise in_port[3] -> EDGECAP=0x008, irq=1 at edge 8; write
//    EDGECAP=0x008 -> irq=0 two cycles later; write 0x000 leaves flag set.
//  4 Edge select: EDGESEL=01, toggle in_port[0] 0->1->0 (each held 10 cycles) -> only falling
//    sets EDGECAP[0]; EDGESEL=10 -> both edges set it.
//  5 Collision: W1C of EDGECAP[5] in the same cycle a new edge on bit 5 is captured -> bit 5
//    reads 1 afterwards; mask=0 keeps irq=0 while EDGECAP!=0.
//  6 Reset mid-debounce: assert reset while counter at 2 -> after release DATA=0, EDGECAP=0,
//    then pin still high yields a fresh rising edge after a full DEBOUNCE_CYCLES.

Source files
------------

// File: rtl/chaves_debounce_irq_ctrl.sv
// Avalon-MM slide-switch controller: per-bit synchronizer and debouncer, edge capture
// with write-1-to-clear flags, and a maskable level interrupt toward the HPS.
module chaves_debounce_irq_ctrl #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int             CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] deb, deb_q;
  logic [WIDTH-1:0] edgecap, irqmask;
  logic [1:0]       edgesel;
  logic [CW-1:0]    cnt [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en        = chipselect & write;
  // absorbs writedata bits above WIDTH that no register stores
  assign unused_wdata = ^writedata;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rise = deb & ~deb_q;
    fall = ~deb & deb_q;
    if (edgesel[1])      ev = rise | fall;
    else if (edgesel[0]) ev = fall;
    else                 ev = rise;

    clr = '0;
    if (wr_en && address == 2'd2) clr = writedata[WIDTH-1:0];

    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd1:    rd_mux[WIDTH-1:0] = irqmask;
      2'd2:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux[1:0]       = edgesel;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, e.g. deb_q really is deb from the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      deb      <= '0;
      deb_q    <= '0;
      edgecap  <= '0;
      irqmask  <= '0;
      edgesel  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
      // NOTE: the counter array is reset too, because a reset mid-debounce must
      // restart the full stability window rather than resume a partial count.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1    <= in_port;
      s2    <= s1;
      deb_q <= deb;

      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end

      // a new edge overrides a same-cycle W1C clear of that bit
      edgecap <= (edgecap & ~clr) | ev;

      if (wr_en && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
      if (wr_en && address == 2'd3) edgesel <= writedata[1:0];

      irq      <= |(edgecap & irqmask);
      readdata <= rd_mux;
    end
  end

endmodule
